// File: rtl/galois_lfsr_pkg.sv
// Definitions shared by the 8-bit Galois LFSR generator and its downstream PRBS checker.
package galois_lfsr_pkg;

   localparam logic [7:0] LFSR8_TAPS = 8'h1D;

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} prbs_chk_state_t;

   // hist[k] holds s[n-1-k]; returns s[n] = s[n-4]^s[n-5]^s[n-6]^s[n-8].
   function automatic logic prbs8_predict(input logic [7:0] hist);
      return hist[3] ^ hist[4] ^ hist[5] ^ hist[7];
   endfunction

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS8 checker: hunts for the sequence, verifies it, then flywheels
// a local reference and counts bit errors while locked.
import galois_lfsr_pkg::*;

module prbs_checker #(
   parameter int LOCK_COUNT  = 16,
   parameter int WINDOW_BITS = 64,
   parameter int LOSS_THRESH = 8,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic                 in_bit,
   input  logic                 clear_counters,
   output logic                 locked,
   output logic                 error_pulse,
   output logic [CNT_WIDTH-1:0] bit_count,
   output logic [CNT_WIDTH-1:0] err_count
);

   // Stream semantics: in_valid qualifies in_bit for exactly one cycle; there is no
   // ready/backpressure, so every valid bit is consumed in the cycle it is presented.

   localparam logic [7:0]           LOCK_N  = 8'(LOCK_COUNT);
   localparam logic [15:0]          WIN_N   = 16'(WINDOW_BITS);
   localparam logic [15:0]          LOSS_N  = 16'(LOSS_THRESH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   prbs_chk_state_t      state_q, state_d;
   logic [7:0]           hist_q, hist_d;
   logic [3:0]           fill_q, fill_d;
   logic [7:0]           run_q, run_d;
   logic [15:0]          win_cnt_q, win_cnt_d;
   logic [15:0]          win_err_q, win_err_d;
   logic                 locked_q, locked_d;
   logic                 err_pulse_q, err_pulse_d;
   logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic                 pred;
   logic                 mismatch;

   always_comb begin
      state_d     = state_q;
      hist_d      = hist_q;
      fill_d      = fill_q;
      run_d       = run_q;
      win_cnt_d   = win_cnt_q;
      win_err_d   = win_err_q;
      bit_cnt_d   = bit_cnt_q;
      err_cnt_d   = err_cnt_q;
      err_pulse_d = 1'b0;
      pred        = prbs8_predict(hist_q);
      mismatch    = in_bit ^ pred;

      if (in_valid) begin
         case (state_q)
            HUNT: begin
               hist_d = {hist_q[6:0], in_bit};
               if (fill_q != 4'd8) fill_d = fill_q + 4'd1;
               // An all-zero history is the LFSR's dead state and can never be verified.
               if (fill_d == 4'd8 && hist_d != 8'h00) begin
                  state_d = VERIFY;
                  run_d   = 8'd0;
               end
            end
            VERIFY: begin
               hist_d = {hist_q[6:0], in_bit};
               if (!mismatch) begin
                  run_d = run_q + 8'd1;
                  if (run_d == LOCK_N) begin
                     state_d   = LOCKED;
                     win_cnt_d = 16'd0;
                     win_err_d = 16'd0;
                  end
               end else begin
                  state_d = HUNT;
                  fill_d  = 4'd0;
               end
            end
            LOCKED: begin
               // Flywheel: the reference advances on its own prediction, so a corrupted
               // received bit cannot pollute the history.
               hist_d    = {hist_q[6:0], pred};
               win_cnt_d = win_cnt_q + 16'd1;
               if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  win_err_d   = win_err_q + 16'd1;
                  if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
               end
               if (win_err_d == LOSS_N) begin
                  state_d = HUNT;
                  fill_d  = 4'd0;
               end else if (win_cnt_d == WIN_N) begin
                  win_cnt_d = 16'd0;
                  win_err_d = 16'd0;
               end
            end
            default: state_d = HUNT;
         endcase
      end

      if (clear_counters) begin
         bit_cnt_d = '0;
         err_cnt_d = '0;
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= HUNT;
         hist_q      <= 8'h00;
         fill_q      <= 4'd0;
         run_q       <= 8'd0;
         win_cnt_q   <= 16'd0;
         win_err_q   <= 16'd0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         bit_cnt_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         run_q       <= run_d;
         win_cnt_q   <= win_cnt_d;
         win_err_q   <= win_err_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         bit_cnt_q   <= bit_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign locked      = locked_q;
   assign error_pulse = err_pulse_q;
   assign bit_count   = bit_cnt_q;
   assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a wide-counter and a 4-bit-counter instance share one stimulus
// stream; a behavioural model feeds expected-output queues that a monitor drains.
module tb_prbs_checker;

   localparam int LOCK_COUNT  = 16;
   localparam int WINDOW_BITS = 64;
   localparam int LOSS_THRESH = 8;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_bit;
   logic        clear_counters;
   logic        locked_a, pulse_a;
   logic [31:0] bit_count_a, err_count_a;
   logic        locked_b, pulse_b;
   logic [3:0]  bit_count_b, err_count_b;

   int total = 0;
   int bad   = 0;

   prbs_checker #(.LOCK_COUNT(LOCK_COUNT), .WINDOW_BITS(WINDOW_BITS),
                  .LOSS_THRESH(LOSS_THRESH), .CNT_WIDTH(32)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
      .clear_counters(clear_counters), .locked(locked_a), .error_pulse(pulse_a),
      .bit_count(bit_count_a), .err_count(err_count_a));

   prbs_checker #(.LOCK_COUNT(LOCK_COUNT), .WINDOW_BITS(WINDOW_BITS),
                  .LOSS_THRESH(LOSS_THRESH), .CNT_WIDTH(4)) u_dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
      .clear_counters(clear_counters), .locked(locked_b), .error_pulse(pulse_b),
      .bit_count(bit_count_b), .err_count(err_count_b));

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helper ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   typedef enum int {M_HUNT, M_VERIFY, M_LOCKED} mode_t;
   mode_t       m_mode;
   bit          hq[$];          // hq[0] is the most recent history bit
   int          m_fill, m_run, m_wcnt, m_werr;
   logic [31:0] bc32, ec32;
   logic [3:0]  bc4, ec4;
   bit          m_pulse;

   logic [65:0] exp_q[$];
   logic [9:0]  exp4_q[$];

   task automatic model_reset();
      m_mode = M_HUNT;
      hq = {};
      repeat (8) hq.push_back(1'b0);
      m_fill = 0; m_run = 0; m_wcnt = 0; m_werr = 0;
      bc32 = 0; ec32 = 0; bc4 = 0; ec4 = 0;
      m_pulse = 0;
   endtask

   function automatic bit history_next();
      return hq[3] ^ hq[4] ^ hq[5] ^ hq[7];
   endfunction

   task automatic history_push(input bit b);
      hq.push_front(b);
      hq.delete(8);
   endtask

   task automatic model_step(input bit v, input bit b, input bit clr);
      bit p;
      bit nonzero;
      m_pulse = 0;
      if (v) begin
         p = history_next();
         if (m_mode == M_HUNT) begin
            history_push(b);
            if (m_fill < 8) m_fill++;
            nonzero = 0;
            foreach (hq[k]) if (hq[k]) nonzero = 1;
            if (m_fill == 8 && nonzero) begin
               m_mode = M_VERIFY;
               m_run  = 0;
            end
         end else if (m_mode == M_VERIFY) begin
            history_push(b);
            if (b == p) begin
               m_run++;
               if (m_run == LOCK_COUNT) begin
                  m_mode = M_LOCKED; m_wcnt = 0; m_werr = 0;
               end
            end else begin
               m_mode = M_HUNT; m_fill = 0;
            end
         end else begin
            history_push(p);
            if (bc32 != 32'hFFFF_FFFF) bc32++;
            if (bc4 != 4'hF) bc4++;
            if (b != p) begin
               m_pulse = 1;
               m_werr++;
               if (ec32 != 32'hFFFF_FFFF) ec32++;
               if (ec4 != 4'hF) ec4++;
            end
            m_wcnt++;
            if (m_werr >= LOSS_THRESH) begin
               m_mode = M_HUNT; m_fill = 0;
            end else if (m_wcnt >= WINDOW_BITS) begin
               m_wcnt = 0; m_werr = 0;
            end
         end
      end
      if (clr) begin
         bc32 = 0; ec32 = 0; bc4 = 0; ec4 = 0;
      end
      exp_q.push_back({(m_mode == M_LOCKED) ? 1'b1 : 1'b0, m_pulse, bc32, ec32});
      exp4_q.push_back({(m_mode == M_LOCKED) ? 1'b1 : 1'b0, m_pulse, bc4, ec4});
   endtask

   // ---------------- reference generator stream ----------------
   bit gs[$];

   function automatic bit gen_next();
      int n;
      bit b;
      n = gs.size();
      if (n < 7)       b = 1'b0;
      else if (n == 7) b = 1'b1;
      else             b = gs[n-4] ^ gs[n-5] ^ gs[n-6] ^ gs[n-8];
      gs.push_back(b);
      return b;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input bit v, input bit b, input bit clr);
      @(negedge clk);
      in_valid       = v;
      in_bit         = b;
      clear_counters = clr;
      model_step(v, b, clr);
   endtask

   task automatic send_clean(input int n);
      repeat (n) drive(1'b1, gen_next(), 1'b0);
   endtask

   task automatic send_flip(input bit clr);
      drive(1'b1, ~gen_next(), clr);
   endtask

   task automatic peek();
      @(posedge clk);
      #2;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(posedge clk) begin
      logic [65:0] e;
      logic [9:0]  e4;
      #1;
      if (!reset && exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         e4 = exp4_q.pop_front();
         chk("locked",      {63'd0, locked_a}, {63'd0, e[65]});
         chk("error_pulse", {63'd0, pulse_a},  {63'd0, e[64]});
         chk("bit_count",   {32'd0, bit_count_a}, {32'd0, e[63:32]});
         chk("err_count",   {32'd0, err_count_a}, {32'd0, e[31:0]});
         chk("locked_w4",      {63'd0, locked_b}, {63'd0, e4[9]});
         chk("error_pulse_w4", {63'd0, pulse_b},  {63'd0, e4[8]});
         chk("bit_count_w4",   {60'd0, bit_count_b}, {60'd0, e4[7:4]});
         chk("err_count_w4",   {60'd0, err_count_b}, {60'd0, e4[3:0]});
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_counters = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_locked", {63'd0, locked_a}, 64'd0);
      chk("reset_pulse",  {63'd0, pulse_a},  64'd0);
      chk("reset_bits",   {32'd0, bit_count_a}, 64'd0);
      chk("reset_errs",   {32'd0, err_count_a}, 64'd0);
      reset = 1'b0;

      // Lock acquisition from seed 8'h01.
      send_clean(23);
      peek(); chk("lock_not_yet_23", {63'd0, locked_a}, 64'd0);
      send_clean(1);
      peek(); chk("lock_at_24", {63'd0, locked_a}, 64'd1);
      send_clean(1000);
      peek();
      chk("bits_after_1000", {32'd0, bit_count_a}, 64'd1000);
      chk("errs_after_1000", {32'd0, err_count_a}, 64'd0);
      chk("bits_w4_saturated", {60'd0, bit_count_b}, 64'd15);

      // Single-bit error absorbed by the flywheel.
      send_flip(1'b0);
      peek();
      chk("single_err_pulse",  {63'd0, pulse_a}, 64'd1);
      chk("single_err_count",  {32'd0, err_count_a}, 64'd1);
      chk("single_err_locked", {63'd0, locked_a}, 64'd1);
      send_clean(1);
      peek(); chk("single_err_pulse_off", {63'd0, pulse_a}, 64'd0);
      send_clean(49);
      peek(); chk("flywheel_no_errs", {32'd0, err_count_a}, 64'd1);

      // Loss of lock: 8 errors inside one window, then relock.
      for (int i = 0; i < 8; i++) begin
         send_flip(1'b0);
         if (i < 7) send_clean(2);
      end
      peek();
      chk("loss_unlocked", {63'd0, locked_a}, 64'd0);
      chk("loss_err_count", {32'd0, err_count_a}, 64'd9);
      send_clean(23);
      peek(); chk("relock_not_yet", {63'd0, locked_a}, 64'd0);
      send_clean(1);
      peek(); chk("relock_at_24", {63'd0, locked_a}, 64'd1);

      // All-zero input, then a gapped clean stream from the seed.
      repeat (100) drive(1'b1, 1'b0, 1'b0);
      peek(); chk("zeros_stay_hunt", {63'd0, locked_a}, 64'd0);
      gs = {};
      for (int i = 0; i < 45; i++) begin
         if (i % 2 == 0) drive(1'b1, gen_next(), 1'b0);
         else            drive(1'b0, 1'b0, 1'b0);
      end
      peek(); chk("gapped_not_yet", {63'd0, locked_a}, 64'd0);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, gen_next(), 1'b0);
      peek(); chk("gapped_lock", {63'd0, locked_a}, 64'd1);

      // Clear on the same cycle as an errored bit.
      send_clean(30);
      send_flip(1'b1);
      peek();
      chk("clr_pulse", {63'd0, pulse_a}, 64'd1);
      chk("clr_bits",  {32'd0, bit_count_a}, 64'd0);
      chk("clr_errs",  {32'd0, err_count_a}, 64'd0);
      drive(1'b1, gen_next(), 1'b0);

      // Reset mid-lock with three errors recorded.
      for (int i = 0; i < 3; i++) begin
         send_flip(1'b0);
         send_clean(3);
      end
      peek();
      chk("pre_reset_errs", {32'd0, err_count_a}, 64'd3);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_locked", {63'd0, locked_a}, 64'd0);
      chk("async_rst_bits",   {32'd0, bit_count_a}, 64'd0);
      chk("async_rst_errs",   {32'd0, err_count_a}, 64'd0);
      chk("async_rst_errs_w4", {60'd0, err_count_b}, 64'd0);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      gs = {};
      send_clean(23);
      peek(); chk("post_rst_not_yet", {63'd0, locked_a}, 64'd0);
      send_clean(1);
      peek(); chk("post_rst_lock", {63'd0, locked_a}, 64'd1);

      // Randomised traffic: gaps, sparse bit errors, occasional counter clears.
      for (int i = 0; i < 3000; i++) begin
         bit v, b, clr;
         v   = ($urandom_range(3, 0) != 0);
         clr = ($urandom_range(99, 0) == 0);
         b   = 1'b0;
         if (v) begin
            b = gen_next();
            if ($urandom_range(39, 0) == 0) b = ~b;
         end
         drive(v, b, clr);
      end

      drive(1'b0, 1'b0, 1'b0);
      peek();
      peek();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
